// File: rtl/dmem_responder_if.sv
// Request/response channel between the datapath initiator and the data-memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: one request at a time, response after a fixed latency,
// byte-strobed stores and range/alignment error reporting.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  dmem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               lat_we;
  logic [31:0]        lat_addr;
  logic [31:0]        lat_wdata;
  logic [3:0]         lat_wstrb;
  logic               cur_we;
  logic [31:0]        cur_addr;
  logic [31:0]        cur_wdata;
  logic [3:0]         cur_wstrb;
  logic               cur_err;
  logic               enter_resp;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]        mem [DEPTH];

  // With LATENCY==1 the access happens on the accept edge itself, so take the live request.
  always_comb begin
    cur_we    = lat_we;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_wstrb = lat_wstrb;
    if (state == IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_wstrb = bus.req_wstrb;
    end
  end

  assign cur_err    = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign idx        = cur_addr[ADDR_WIDTH+1:2];
  assign enter_resp = (next_state == RESP) && (state != RESP);

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            cnt_next   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          next_state = RESP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_we         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_wstrb      <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      state          <= next_state;
      cnt            <= cnt_next;
      bus.req_ready  <= (next_state == IDLE);
      bus.resp_valid <= (next_state == RESP);
      if (state == IDLE && bus.req_valid) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_wstrb <= bus.req_wstrb;
      end
      if (enter_resp) begin
        bus.resp_err   <= cur_err;
        bus.resp_rdata <= (cur_err || cur_we) ? 32'd0 : mem[idx];
      end
    end
  end

  // Array is deliberately not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset_n && enter_resp && cur_we && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_wstrb[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written corner sequences and
// randomized traffic against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned LAT2 = 2;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  dmem_responder_if bus2 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // One transaction on the LATENCY=2 instance; holds resp_ready low for 'hold' cycles.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input int hold,
                     output logic [31:0] rd, output logic er);
    int k;
    bit seen;
    @(negedge clk);
    chk("req_ready_idle", 32'(bus2.req_ready), 32'd1);
    bus2.req_valid = 1'b1;
    bus2.req_we    = we;
    bus2.req_addr  = addr;
    bus2.req_wdata = wdata;
    bus2.req_wstrb = wstrb;
    @(posedge clk);
    #1;
    bus2.req_valid = 1'b0;
    bus2.req_we    = 1'($urandom);
    bus2.req_addr  = $urandom;
    bus2.req_wdata = $urandom;
    bus2.req_wstrb = 4'($urandom);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (bus2.resp_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk("resp_timeout", 32'd0, 32'd1);
      rd = 'x;
      er = 1'bx;
      return;
    end
    chk("latency", 32'(k), 32'(LAT2));
    rd = bus2.resp_rdata;
    er = bus2.resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus2.resp_valid), 32'd1);
      chk("hold_rdata", bus2.resp_rdata, rd);
      chk("hold_err", 32'(bus2.resp_err), 32'(er));
      chk("hold_req_ready", 32'(bus2.req_ready), 32'd0);
    end
    bus2.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus2.resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] model [32];
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
    logic        exp_err;
    logic [31:0] exp_rd;
    time         prev_acc;
    int          r;
    int          w;
    logic [31:0] l1_addr [5];
    logic [31:0] l1_wdata [5];
    logic [3:0]  l1_wstrb [5];
    logic        l1_we [5];
    logic [31:0] l1_exp [5];
    logic        l1_err [5];

    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,   32'h000000AA, 4'h1, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b0, 32'h12,   32'h0,        4'h0, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 32'h0,    32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 32'h1000, 32'h55667788, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h11223344, 1'b0};
    vecs[8]  = '{1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    vecs[10] = '{1'b1, 32'h10,   32'hCC000000, 4'h8, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 32'hFFC,  32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 32'h11,   32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[13] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};

    reset_n = 1'b0;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0;
    bus2.req_wdata = '0;   bus2.req_wstrb = '0; bus2.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
    bus1.req_wdata = '0;   bus1.req_wstrb = '0; bus1.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(bus2.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus2.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus2.resp_err), 32'd0);
    chk("rst_req_ready", 32'(bus2.req_ready), 32'd1);
    chk("rst1_resp_valid", 32'(bus1.resp_valid), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, i % 2, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Stall the response for 5 cycles, then expect IDLE right after the handshake.
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
    chk("stall_rdata", rd, 32'hCCADBEAA);
    chk("stall_err", 32'(er), 32'd0);
    @(negedge clk);
    chk("post_hs_req_ready", 32'(bus2.req_ready), 32'd1);
    chk("post_hs_resp_valid", 32'(bus2.resp_valid), 32'd0);

    // Reset during WAIT of a store must drop it.
    txn(1'b1, 32'h20, 32'h01020304, 4'hF, 0, rd, er);
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 32'h20;
    bus2.req_wdata = 32'hFFFFFFFF; bus2.req_wstrb = 4'hF;
    @(posedge clk);
    #1;
    bus2.req_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(bus2.resp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(bus2.req_ready), 32'd1);
    chk("midrst_resp_valid2", 32'(bus2.resp_valid), 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    chk("midrst_old_data", rd, 32'h01020304);
    chk("midrst_err", 32'(er), 32'd0);

    // LATENCY=1 instance: back-to-back traffic, one transaction every two cycles.
    l1_we[0] = 1'b1; l1_addr[0] = 32'h8; l1_wdata[0] = 32'hCAFEF00D; l1_wstrb[0] = 4'hF; l1_exp[0] = 32'h0;        l1_err[0] = 1'b0;
    l1_we[1] = 1'b0; l1_addr[1] = 32'h8; l1_wdata[1] = 32'h0;        l1_wstrb[1] = 4'h0; l1_exp[1] = 32'hCAFEF00D; l1_err[1] = 1'b0;
    l1_we[2] = 1'b0; l1_addr[2] = 32'h9; l1_wdata[2] = 32'h0;        l1_wstrb[2] = 4'h0; l1_exp[2] = 32'h0;        l1_err[2] = 1'b1;
    l1_we[3] = 1'b1; l1_addr[3] = 32'h8; l1_wdata[3] = 32'h00005500; l1_wstrb[3] = 4'h2; l1_exp[3] = 32'h0;        l1_err[3] = 1'b0;
    l1_we[4] = 1'b0; l1_addr[4] = 32'h8; l1_wdata[4] = 32'h0;        l1_wstrb[4] = 4'h0; l1_exp[4] = 32'hCAFE550D; l1_err[4] = 1'b0;
    bus1.resp_ready = 1'b1;
    prev_acc = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("l1_req_ready%0d", j), 32'(bus1.req_ready), 32'd1);
      bus1.req_valid = 1'b1; bus1.req_we = l1_we[j]; bus1.req_addr = l1_addr[j];
      bus1.req_wdata = l1_wdata[j]; bus1.req_wstrb = l1_wstrb[j];
      @(posedge clk);
      if (j > 0) chk($sformatf("l1_period%0d", j), 32'($time - prev_acc), 32'd20);
      prev_acc = $time;
      @(negedge clk);
      chk($sformatf("l1_valid%0d", j), 32'(bus1.resp_valid), 32'd1);
      chk($sformatf("l1_rdata%0d", j), bus1.resp_rdata, l1_exp[j]);
      chk($sformatf("l1_err%0d", j), 32'(bus1.resp_err), 32'(l1_err[j]));
    end
    bus1.req_valid = 1'b0;

    // Randomized traffic over words 16..31 against the reference word array.
    for (int i = 16; i < 32; i++) begin
      model[i] = $urandom;
      txn(1'b1, 32'(i * 4), model[i], 4'hF, 0, rd, er);
    end
    for (int n = 0; n < 80; n++) begin
      w    = 16 + int'($urandom_range(0, 15));
      addr = 32'(w * 4);
      r    = int'($urandom_range(0, 9));
      if (r == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (r == 1) addr = addr | (32'h1000 << $urandom_range(0, 19));
      we      = 1'($urandom);
      wdata   = $urandom;
      wstrb   = 4'($urandom);
      exp_err = (addr % 4 != 0) || (addr >= 32'd4096);
      exp_rd  = 32'd0;
      if (!exp_err && !we) exp_rd = model[addr / 4];
      if (!exp_err && we) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) model[addr / 4][8*b +: 8] = wdata[8*b +: 8];
      end
      txn(we, addr, wdata, wstrb, int'($urandom_range(0, 2)), rd, er);
      chk($sformatf("rand%0d_rdata", n), rd, exp_rd);
      chk($sformatf("rand%0d_err", n), 32'(er), 32'(exp_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
